lcd_menu_ctrl: RTL and testbench

Parametrised successor to the LED-menu LCD driver. It runs a menu over `NUM_LEDS` LEDs: buttons step through entries, select lights one LED, and back returns to the menu. It drives an HD44780-compatible 16x2 character LCD in 8-bit mode with a real power-up init sequence, timed EN strobes, and full-line redraws. It sits between the debounced push-button inputs and the board's LCD/LED pins.

---
 rtl/lcd_menu_ctrl.sv | 149 ++++++++++++++
 tb/tb_lcd_menu_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lcd_menu_ctrl.sv
// lcd_menu_ctrl: LED menu driving an HD44780 16x2 LCD in 8-bit mode.
// Define LCD_STATUS_LINE_EN to also draw an LED status line on row 2.
module lcd_menu_ctrl #(
  parameter int NUM_LEDS    = 5,
  parameter int EN_CYCLES   = 50,
  parameter int WAIT_CYCLES = 2000,
  parameter int INIT_WAIT   = 750000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [3:0]          entrada,
  output logic                LCD_RS,
  output logic                LCD_RW,
  output logic                LCD_EN,
  output logic [7:0]          LCD_DATA,
  output logic [NUM_LEDS-1:0] LED,
  output logic                busy
);
  localparam int MAX_EW = EN_CYCLES > WAIT_CYCLES ? EN_CYCLES : WAIT_CYCLES;
  localparam int MAXC   = INIT_WAIT > MAX_EW ? INIT_WAIT : MAX_EW;
  localparam int CW     = $clog2(MAXC + 1);
`ifdef LCD_STATUS_LINE_EN
  localparam logic [5:0] LAST = 6'd33;
`else
  localparam logic [5:0] LAST = 6'd16;
`endif
  localparam logic [2:0] PWR_WAIT = 3'd0, INIT_CMD = 3'd1, CLR_WAIT = 3'd2, IDLE = 3'd3,
                         XFER_SETUP = 3'd4, XFER_EN = 3'd5, XFER_WAIT = 3'd6;
  localparam logic [39:0] ACESO = "ACESO";
  localparam logic [31:0] LEDT  = "LED ";
  logic [2:0]    eng;
  logic [CW-1:0] cnt;
  logic [5:0]    pos;
  logic          ini, lit, ev, acc;
  logic [3:0]    idx, prev_in;
  assign LCD_RW = 1'b0;
  assign busy   = eng != IDLE;
  always_comb begin
    ev  = $onehot(entrada) && prev_in == 4'b0000 && !busy;
    acc = ev && (lit ? entrada[0] : !entrada[0]);
  end
  // {rs, data} for sequence slot p; redraw slots are 0x80, 16 text bytes, then the optional row 2
  function automatic logic [8:0] lcd_byte(input logic init_b, input logic [5:0] p);
    logic [7:0] n;
    int c;
    n = 8'h31 + 8'(idx);
    if (init_b)
      return {1'b0, p == 6'd0 ? 8'h38 : p == 6'd1 ? 8'h0C : p == 6'd2 ? 8'h06 : 8'h01};
    if (p == 6'd0)
      return {1'b0, 8'h80};
    if (p <= 6'd16) begin
      c = int'(p) - 1;
      return {1'b1, lit ? (c < 5 ? ACESO[8*(4-c) +: 8] : c == 6 ? n : 8'h20)
                        : (c < 4 ? LEDT[8*(3-c) +: 8] : c == 4 ? n : 8'h20)};
    end
`ifdef LCD_STATUS_LINE_EN
    if (p == 6'd17)
      return {1'b0, 8'hC0};
    c = int'(p) - 18;
    return {1'b1, c < NUM_LEDS ? ((16'(LED) >> c) & 16'd1) != 16'd0 ? 8'h2A : 8'h2D : 8'h20};
`else
    return {1'b1, 8'h20};
`endif
  endfunction
  always_ff @(posedge Clock) begin
    if (Reset) begin
      eng      <= PWR_WAIT;
      cnt      <= CW'(INIT_WAIT - 1);
      pos      <= '0;
      ini      <= 1'b1;
      LCD_RS   <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_DATA <= 8'h00;
      LED      <= '0;
      lit      <= 1'b0;
      idx      <= '0;
      prev_in  <= '0;
    end else begin
      prev_in <= entrada;
      if (acc) begin
        if (entrada[3]) idx <= idx == 4'd0 ? 4'(NUM_LEDS - 1) : idx - 4'd1;
        if (entrada[2]) idx <= idx == 4'(NUM_LEDS - 1) ? 4'd0 : idx + 4'd1;
        if (entrada[1]) begin
          lit <= 1'b1;
          LED <= NUM_LEDS'(1) << idx;
        end
        if (entrada[0]) begin
          lit <= 1'b0;
          LED <= '0;
        end
      end
      case (eng)
        PWR_WAIT: begin
          if (cnt == '0) eng <= INIT_CMD;
          else cnt <= cnt - 1'b1;
        end
        INIT_CMD: begin
          if (pos == 6'd4) begin
            eng <= CLR_WAIT;
            cnt <= CW'(INIT_WAIT - 1);
          end else begin
            {LCD_RS, LCD_DATA} <= lcd_byte(1'b1, pos);
            eng <= XFER_SETUP;
          end
        end
        CLR_WAIT: begin
          if (cnt == '0) begin
            ini <= 1'b0;
            pos <= '0;
            {LCD_RS, LCD_DATA} <= lcd_byte(1'b0, 6'd0);
            eng <= XFER_SETUP;
          end else cnt <= cnt - 1'b1;
        end
        IDLE: begin
          if (acc) begin
            pos <= '0;
            {LCD_RS, LCD_DATA} <= lcd_byte(1'b0, 6'd0);
            eng <= XFER_SETUP;
          end
        end
        XFER_SETUP: begin
          LCD_EN <= 1'b1;
          cnt    <= CW'(EN_CYCLES - 1);
          eng    <= XFER_EN;
        end
        XFER_EN: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b0;
            cnt    <= CW'(WAIT_CYCLES - 1);
            eng    <= XFER_WAIT;
          end else cnt <= cnt - 1'b1;
        end
        XFER_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (ini) begin
            pos <= pos + 6'd1;
            eng <= INIT_CMD;
          end else if (pos == LAST) eng <= IDLE;
          else begin
            pos <= pos + 6'd1;
            {LCD_RS, LCD_DATA} <= lcd_byte(1'b0, pos + 6'd1);
            eng <= XFER_SETUP;
          end
        end
        default: eng <= PWR_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_menu_ctrl.sv
// tb_lcd_menu_ctrl: scoreboard bench for lcd_menu_ctrl with a short-timing configuration.
module tb_lcd_menu_ctrl;
  localparam int NL = 5;
`ifdef LCD_STATUS_LINE_EN
  localparam int LEN = 34;
`else
  localparam int LEN = 17;
`endif
  localparam int XF = LEN * 7;
  logic          clk = 1'b0, rst = 1'b1;
  logic [3:0]    entrada = 4'b0000;
  logic          LCD_RS, LCD_RW, LCD_EN, busy;
  logic [7:0]    LCD_DATA;
  logic [NL-1:0] LED;
  logic [8:0]    q[$];
  logic [8:0]    cap;
  logic          en_prev = 1'b0;
  int            en_hi = 0, brun = 0, last_run = 0, rises = 0;
  int            n_chk = 0, n_fail = 0;
  int            m_idx = 0;
  logic          m_lit = 1'b0;

  lcd_menu_ctrl #(.NUM_LEDS(NL), .EN_CYCLES(2), .WAIT_CYCLES(4), .INIT_WAIT(20)) dut (
    .Clock(clk), .Reset(rst), .entrada(entrada), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA), .LED(LED), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_redraw();
    string s;
    s = m_lit ? $sformatf("ACESO %0d", m_idx + 1) : $sformatf("LED %0d", m_idx + 1);
    q.push_back({1'b0, 8'h80});
    for (int c = 0; c < 16; c++) q.push_back({1'b1, c < s.len() ? s[c] : 8'h20});
`ifdef LCD_STATUS_LINE_EN
    q.push_back({1'b0, 8'hC0});
    for (int k = 0; k < 16; k++)
      q.push_back({1'b1, k < NL ? ((m_lit && k == m_idx) ? 8'h2A : 8'h2D) : 8'h20});
`endif
  endtask

  task automatic push_init();
    q.push_back({1'b0, 8'h38});
    q.push_back({1'b0, 8'h0C});
    q.push_back({1'b0, 8'h06});
    q.push_back({1'b0, 8'h01});
    push_redraw();
  endtask

  task automatic press(input logic [3:0] b, input int hold);
    @(negedge clk);
    entrada = b;
    repeat (hold) @(negedge clk);
    entrada = 4'b0000;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((busy || q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < budget, 1);
    @(negedge clk);
  endtask

  task automatic release_and_time();
    int n = 0;
    @(negedge clk);
    rst = 1'b0;
    do begin
      @(negedge clk);
      n++;
    end while (!LCD_EN && n < 100);
    chk("init_wait", n >= 20 && n <= 24, 1);
    wait_idle(2000);
  endtask

  task automatic step(input logic [3:0] b, input int hold, input logic [NL-1:0] led_exp);
    int r0 = rises;
    push_redraw();
    press(b, hold);
    chk("busy_rise", busy, 1);
    chk("led_upd", LED, led_exp);
    wait_idle(1000);
    chk("busy_len", last_run, XF);
    chk("xfers", rises - r0, LEN);
  endtask

  task automatic ignored(input string tag, input logic [3:0] b);
    int r0 = rises;
    logic [NL-1:0] l0 = LED;
    press(b, 1);
    repeat (30) @(negedge clk);
    chk(tag, rises - r0, 0);
    chk({tag, "_led"}, LED, l0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      en_prev <= 1'b0;
      en_hi   <= 0;
      brun    <= 0;
    end else begin
      en_prev <= LCD_EN;
      if (LCD_EN && !en_prev) begin
        rises <= rises + 1;
        en_hi <= 1;
        cap   <= {LCD_RS, LCD_DATA};
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) chk("lcd_byte", {LCD_RS, LCD_DATA}, q.pop_front());
      end else if (LCD_EN) en_hi <= en_hi + 1;
      if (!LCD_EN && en_prev) begin
        chk("en_width", en_hi, 2);
        chk("rs_data_hold", {LCD_RS, LCD_DATA}, cap);
      end
      brun <= busy ? brun + 1 : 0;
      if (!busy && brun != 0) last_run <= brun;
    end
  end

  initial begin
    int r0, n;
    repeat (3) @(negedge clk);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_rw", LCD_RW, 0);
    chk("rst_en", LCD_EN, 0);
    chk("rst_data", LCD_DATA, 0);
    chk("rst_led", LED, 0);
    chk("rst_busy", busy, 1);
    push_init();
    release_and_time();
    chk("init_led", LED, 0);
    chk("init_busy", busy, 0);
    chk("init_rw", LCD_RW, 0);
    for (int i = 0; i < 3; i++) begin
      m_idx++;
      step(4'b0100, 1, '0);
    end
    m_idx = 4; step(4'b0100, 1, '0);
    m_idx = 0; step(4'b0100, 1, '0);
    m_idx = 4; step(4'b1000, 1, '0);
    m_idx = 3; step(4'b1000, 1, '0);
    m_idx = 2; step(4'b1000, 1, '0);
    m_lit = 1'b1; step(4'b0010, 1, 5'b00100);
    ignored("lit_next", 4'b0100);
    ignored("lit_prev", 4'b1000);
    m_lit = 1'b0; step(4'b0001, 1, '0);
    ignored("menu_back", 4'b0001);
    ignored("two_hot", 4'b0110);
    // second press lands mid-redraw and must be dropped
    r0 = rises;
    m_idx = 3;
    push_redraw();
    press(4'b0100, 1);
    repeat (3) @(negedge clk);
    press(4'b0100, 1);
    wait_idle(1000);
    chk("busy_drop", rises - r0, LEN);
    m_idx = 4; step(4'b0100, 100, '0);
    m_lit = 1'b1;
    push_redraw();
    press(4'b0010, 1);
    chk("pre_rst_led", LED, 5'b10000);
    n = 0;
    while (!LCD_EN && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("en_seen", LCD_EN, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", LCD_EN, 0);
    chk("mid_rst_led", LED, 0);
    chk("mid_rst_busy", busy, 1);
    q.delete();
    m_idx = 0;
    m_lit = 1'b0;
    push_init();
    release_and_time();
    chk("reinit_busy", busy, 0);
    m_idx = 1; step(4'b0100, 1, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
